i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver_if.sv | 24 ++
 rtl/i2s_receiver.sv | 159 +++++++++++++++
 tb/tb_i2s_receiver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: raw serial inputs from the transmitter side and the
// recovered stereo sample outputs.
interface i2s_receiver_if #(
  parameter int N = 16
);
  logic         i_SCLK;
  logic         i_LRCLK;
  logic         i_SDIN;
  logic [N-1:0] o_Left_Sample;
  logic [N-1:0] o_Right_Sample;
  logic         o_Sample_DV;
  logic         o_Locked;
  logic         o_Frame_Err;

  modport slave (
    input  i_SCLK, i_LRCLK, i_SDIN,
    output o_Left_Sample, o_Right_Sample, o_Sample_DV, o_Locked, o_Frame_Err
  );

  modport master (
    output i_SCLK, i_LRCLK, i_SDIN,
    input  o_Left_Sample, o_Right_Sample, o_Sample_DV, o_Locked, o_Frame_Err
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronizes SCLK/LRCLK/SDIN into i_Clk, aligns on the
// left word select and publishes left/right sample pairs with a valid pulse.
module i2s_receiver #(
  parameter int NUM_OF_AMPLITUDE_BITS = 16,
  parameter int MIN_SCLK_DIV          = 4
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  i2s_receiver_if.slave  bus
);
  localparam int N  = NUM_OF_AMPLITUDE_BITS;
  localparam int CW = $clog2(N + 1);

  // Each SCLK half period must span at least one i_Clk cycle to be observed.
  if (MIN_SCLK_DIV < 2) begin : g_div_check
    $error("MIN_SCLK_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    WAIT_LEFT = 2'd0,
    SKIP      = 2'd1,
    SHIFT     = 2'd2,
    PAD       = 2'd3
  } state_t;

  logic          r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic          r_lr_meta, r_lr_sync, r_lr_prev;
  logic          r_sdin_meta, r_sdin_sync;
  state_t        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [N-2:0]  r_shift;
  logic [N-1:0]  r_staging;
  logic          r_left_valid;
  logic          r_chan;
  logic [N-1:0]  r_left_out;
  logic [N-1:0]  r_right_out;
  logic          r_sample_dv;
  logic          r_locked;
  logic          r_frame_err;

  logic          w_sclk_rise;
  logic          w_lr_change;
  logic          w_last_bit;
  logic [N-1:0]  w_word;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_lr_change = (r_lr_sync != r_lr_prev);
  assign w_last_bit  = (r_bit_cnt == CW'(N - 1));
  assign w_word      = {r_shift, r_sdin_sync};

  // Two-flop synchronizers plus the SCLK history flop for edge detection.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_lr_meta   <= 1'b0;
      r_lr_sync   <= 1'b0;
      r_sdin_meta <= 1'b0;
      r_sdin_sync <= 1'b0;
    end else begin
      r_sclk_meta <= bus.i_SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_lr_meta   <= bus.i_LRCLK;
      r_lr_sync   <= r_lr_meta;
      r_sdin_meta <= bus.i_SDIN;
      r_sdin_sync <= r_sdin_meta;
    end
  end

  // Framing FSM; the bit seen on an LRCLK-change edge is the old word's LSB and is dropped.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state      <= WAIT_LEFT;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_staging    <= '0;
      r_left_valid <= 1'b0;
      r_chan       <= 1'b0;
      r_lr_prev    <= 1'b0;
      r_left_out   <= '0;
      r_right_out  <= '0;
      r_sample_dv  <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sample_dv <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_sclk_rise) begin
        r_lr_prev <= r_lr_sync;
        case (r_state)
          WAIT_LEFT: begin
            if (w_lr_change && !r_lr_sync) begin
              r_state   <= SKIP;
              r_chan    <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_state <= WAIT_LEFT;
            end
          end
          SKIP, SHIFT: begin
            if (w_lr_change) begin
              // Short slot: drop everything partial, keep published samples.
              r_frame_err  <= 1'b1;
              r_locked     <= 1'b0;
              r_left_valid <= 1'b0;
              r_staging    <= '0;
              r_shift      <= '0;
              r_bit_cnt    <= '0;
              r_chan       <= r_lr_sync;
              r_state      <= r_lr_sync ? WAIT_LEFT : SKIP;
            end else begin
              r_shift <= w_word[N-2:0];
              if (w_last_bit) begin
                r_state   <= PAD;
                r_bit_cnt <= CW'(N);
                if (!r_chan) begin
                  r_staging    <= w_word;
                  r_left_valid <= 1'b1;
                end else if (r_left_valid) begin
                  r_left_out   <= r_staging;
                  r_right_out  <= w_word;
                  r_sample_dv  <= 1'b1;
                  r_locked     <= 1'b1;
                  r_left_valid <= 1'b0;
                end else begin
                  r_left_valid <= 1'b0;
                end
              end else begin
                r_state   <= SHIFT;
                r_bit_cnt <= r_bit_cnt + CW'(1);
              end
            end
          end
          PAD: begin
            if (w_lr_change) begin
              r_chan    <= r_lr_sync;
              r_bit_cnt <= '0;
              r_shift   <= '0;
              r_state   <= SKIP;
            end else begin
              r_state <= PAD;
            end
          end
          default: begin
            r_state <= WAIT_LEFT;
          end
        endcase
      end
    end
  end

  assign bus.o_Left_Sample  = r_left_out;
  assign bus.o_Right_Sample = r_right_out;
  assign bus.o_Sample_DV    = r_sample_dv;
  assign bus.o_Locked       = r_locked;
  assign bus.o_Frame_Err    = r_frame_err;
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S transmitter model pushes expected
// sample pairs into a queue that a DV-driven monitor pops and compares.
module tb_i2s_receiver;
  localparam int N    = 16;
  localparam int HALF = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   lsb_cyc;
  int   n_cmp;
  int   n_err;
  int   n_ferr;
  int   n_dv;
  int   n_pushed;
  logic [31:0] exp_q[$];

  i2s_receiver_if #(.N(N)) bus ();

  i2s_receiver #(
    .NUM_OF_AMPLITUDE_BITS(N),
    .MIN_SCLK_DIV(4)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every DV pulse consumes one expected left/right pair.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && bus.o_Sample_DV === 1'b1) begin
      n_dv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_dv: got L=%h R=%h, required no DV (t=%0t)",
                 bus.o_Left_Sample, bus.o_Right_Sample, $time);
      end else begin
        e = exp_q.pop_front();
        check("dv_left",  {16'h0, bus.o_Left_Sample},  {16'h0, e[31:16]});
        check("dv_right", {16'h0, bus.o_Right_Sample}, {16'h0, e[15:0]});
        n_cmp++;
        if ((cyc - lsb_cyc) > 4 || (cyc - lsb_cyc) < 1) begin
          n_err++;
          $display("FAIL dv_latency: got %0d cycles, required 1..4", cyc - lsb_cyc);
        end
      end
    end
  end

  always @(negedge clk) if (!rst && bus.o_Frame_Err === 1'b1) n_ferr++;

  // One SCLK period: data changes while SCLK is low, receiver samples on the rise.
  task automatic bit_out(input logic lr, input logic d, input logic is_lsb);
    bus.i_LRCLK = lr;
    bus.i_SDIN  = d;
    repeat (HALF) @(negedge clk);
    bus.i_SCLK = 1'b1;
    if (is_lsb) lsb_cyc = cyc;
    repeat (HALF) @(negedge clk);
    bus.i_SCLK = 1'b0;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] v, input int len, input logic pad);
    logic d;
    for (int p = 0; p < len; p++) begin
      d = (p >= 1 && p <= N) ? v[N-p] : pad;
      bit_out(lr, d, lr && (p == N));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int len,
                            input logic pad, input logic expect_dv);
    if (expect_dv) begin
      exp_q.push_back({l, r});
      n_pushed++;
    end
    send_slot(1'b0, l, len, pad);
    send_slot(1'b1, r, len, pad);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_left"},  {16'h0, bus.o_Left_Sample},  32'h0);
    check({tag, "_right"}, {16'h0, bus.o_Right_Sample}, 32'h0);
    check({tag, "_dv"},    {31'h0, bus.o_Sample_DV},    32'h0);
    check({tag, "_lock"},  {31'h0, bus.o_Locked},       32'h0);
    check({tag, "_ferr"},  {31'h0, bus.o_Frame_Err},    32'h0);
  endtask

  initial begin
    logic [15:0] l;
    cyc = 0; lsb_cyc = 0; n_cmp = 0; n_err = 0; n_ferr = 0; n_dv = 0; n_pushed = 0;
    rst = 1'b1;
    bus.i_SCLK = 1'b0; bus.i_LRCLK = 1'b1; bus.i_SDIN = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    bit_out(1'b1, 1'b0, 1'b0);
    bit_out(1'b1, 1'b0, 1'b0);

    // Nominal 17-period slots.
    send_frame(16'h1234, 16'hA5A5, 17, 1'b0, 1'b1);
    check("nominal_lock", {31'h0, bus.o_Locked}, 32'h1);
    check("nominal_left_hold", {16'h0, bus.o_Left_Sample}, 32'h1234);

    // 32-period slots with padding driven high.
    send_frame(16'h8000, 16'h7FFF, 32, 1'b1, 1'b1);

    // Short 10-period left slot after lock.
    send_slot(1'b0, 16'h0F0F, 10, 1'b0);
    send_slot(1'b1, 16'hFFFF, 17, 1'b0);
    check("short_ferr_count", n_ferr, 1);
    check("short_unlock", {31'h0, bus.o_Locked}, 32'h0);
    check("short_left_kept",  {16'h0, bus.o_Left_Sample},  32'h8000);
    check("short_right_kept", {16'h0, bus.o_Right_Sample}, 32'h7FFF);
    send_frame(16'h1111, 16'h2222, 17, 1'b0, 1'b1);
    check("relock", {31'h0, bus.o_Locked}, 32'h1);

    // One-cycle reset at left bit 7.
    for (int p = 0; p < 8; p++) bit_out(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midreset");
    for (int p = 8; p < 17; p++) bit_out(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 16'hBEEF, 17, 1'b0);
    send_frame(16'h5A5A, 16'hC3C3, 17, 1'b0, 1'b1);

    // Reset released in the middle of a right slot.
    send_slot(1'b0, 16'hDEAD, 17, 1'b0);
    for (int p = 0; p < 6; p++) bit_out(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int p = 6; p < 17; p++) bit_out(1'b1, 1'b0, 1'b0);
    send_frame(16'h0001, 16'hFFFE, 17, 1'b0, 1'b1);
    send_frame(16'h7F00, 16'h00FF, 17, 1'b0, 1'b1);

    // Ramp of back-to-back frames.
    for (int k = 0; k < 4; k++) begin
      l = 16'h0102 + 16'(k) * 16'h1111;
      send_frame(l, ~l, 17, 1'b0, 1'b1);
    end

    repeat (8) @(negedge clk);
    check("missing_dv", exp_q.size(), 0);
    check("dv_count", n_dv, n_pushed);
    check("final_ferr_count", n_ferr, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
